x86_add_encoder: RTL
====================

Name: x86_add_encoder

Overview:
- Encodes structured x86 ADD instruction descriptors into the byte stream consumed by the instruction decoder.
- The output stream is little-endian 32-bit words.
- The first word of a stream is the start address. All following words are contiguous instruction bytes.
- Sits between the test/stimulus generator and the decoder input (valid/data word interface).

Parameters:
- PAD_BYTE, 8'h90, filler byte used for unused lanes of the final word on flush.
- MAX_INSTR_BYTES, 15, upper bound on encoded instruction length; longer descriptors are rejected.

Ports:
- i_clk  in  1  clock, rising-edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_start  in  1  begin a stream; sampled in IDLE only.
- i_start_addr  in  32  start address emitted as the first word.
- i_instr_valid  in  1  descriptor valid.
- o_instr_ready  out  1  encoder can accept a descriptor.
- i_lock  in  1  prepend F0.
- i_opsize16  in  1  prepend 66.
- i_opcode  in  8  opcode byte.
- i_modrm  in  8  mod/rm byte.
- i_has_sib  in  1  emit i_sib.
- i_sib  in  8  SIB byte.
- i_disp_len  in  3  displacement bytes; legal values 0, 1, 4.
- i_disp  in  32  displacement, emitted LSB first.
- i_imm_len  in  3  immediate bytes; legal values 0, 1, 2, 4.
- i_imm  in  32  immediate, emitted LSB first.
- i_flush  in  1  end the stream; sampled in READY only.
- o_valid  out  1  o_data holds a word.
- o_data  out  32  output word; lane 0 (bits 7:0) is the earliest byte.
- i_out_ready  in  1  downstream accepts the word.
- o_error  out  1  one-cycle pulse when a descriptor is rejected.
- o_done  out  1  one-cycle pulse when the stream has completed.
- o_byte_count  out  32  total instruction bytes packed since start, excluding the address and pad bytes; wraps modulo 2^32.

Behaviour:
- Reset (synchronous; aborts any operation in progress):
  - Outputs: o_valid=0, o_data=0, o_instr_ready=0, o_error=0, o_done=0, o_byte_count=0.
  - Internal: state=IDLE, pack lane count=0.
  - All buffered bytes are discarded.
- Output register: o_data and o_valid are held stable while o_valid=1 and i_out_ready=0. A word transfers on any cycle with o_valid=1 and i_out_ready=1.
- Stall rule: the output register may load only when it is empty or being drained that cycle. Any state step that must load it waits otherwise.
- IDLE:
  - On i_start, the next cycle has o_data=i_start_addr, o_valid=1 and state ADDR.
  - o_byte_count clears at stream start.
- ADDR: after the address word transfers, go to READY.
- READY (o_instr_ready=1):
  - On handshake, latch all fields into a 15-byte buffer.
  - Encoded length L = i_lock + i_opsize16 + 2 + i_has_sib + i_disp_len + i_imm_len.
  - Byte order: F0, 66, opcode, modrm, sib, disp[7:0]..., imm[7:0]...
  - Go to SERIAL; o_instr_ready=0 from the next cycle.
- Rejection: an illegal i_disp_len/i_imm_len, or L > MAX_INSTR_BYTES, rejects the descriptor.
  - o_error pulses on the next cycle.
  - No bytes are packed, o_byte_count is unchanged, and the state stays READY.
- Simultaneous events in READY: i_instr_valid takes priority over i_flush. The flush is ignored that cycle and must be reasserted.
- SERIAL (one byte per cycle):
  - Each cycle, the next byte is written to lane pack_cnt, pack_cnt increments and o_byte_count increments.
  - Writing lane 3 loads the word into the output register and resets pack_cnt to 0.
  - If the load is stalled, the byte waits in the buffer and pack_cnt and o_byte_count do not advance.
  - After byte L-1 is packed, return to READY. Partial lanes persist, so consecutive instructions pack contiguously with no padding.
- FLUSH (entered on i_flush in READY):
  - If pack_cnt>0, fill lanes pack_cnt..3 with PAD_BYTE and load the word, then go to DONE once it transfers.
  - If pack_cnt=0, go straight to DONE with no word.
- DONE: pulse o_done for one cycle, then go to IDLE.
- i_start outside IDLE and i_flush outside READY are ignored.

Test Plan:
- Start and single instruction: reset; start addr 0x00001000; descriptor opcode 01, modrm C8; flush. Required words: 0x00001000, then 0x9090C801; o_byte_count=2; o_done pulses once.
- Word spanning, prefix and imm16: descriptor opsize16=1, opcode 81, modrm C0, imm_len=2, imm 0x1234; flush. Required words after the address: 0x34C08166, then 0x90909012; o_byte_count=5.
- Contiguous packing: three descriptors "00 D8", "03 45 10" (disp_len=1), "05 C0 78 56 34 12" (modrm C0, imm_len=4). The 11 bytes yield 0x4503D800, 0x78C00510, 0x90123456; o_byte_count=11.
- Backpressure: i_out_ready=0 for 5 cycles on the first instruction word. o_data is held stable, serialization stalls with no lost or duplicated bytes, and the word sequence is identical to the unstalled run.
- Illegal descriptor: disp_len=3. o_error pulses once, no words are emitted, o_byte_count is unchanged, and the next legal descriptor is encoded normally.
- Reset mid-operation: assert i_reset during SERIAL with o_valid=1. The next cycle shows all outputs at reset values and state IDLE. A fresh start behaves as in the first scenario.

Source files
------------

// File: rtl/x86_add_encoder_if.sv
// Stream-side bus of the x86 ADD encoder: descriptor input, start/flush control,
// and the 32-bit valid/ready word output toward the decoder.
interface x86_add_encoder_if;
    logic        i_start;
    logic [31:0] i_start_addr;
    logic        i_instr_valid;
    logic        o_instr_ready;
    logic        i_lock;
    logic        i_opsize16;
    logic [7:0]  i_opcode;
    logic [7:0]  i_modrm;
    logic        i_has_sib;
    logic [7:0]  i_sib;
    logic [2:0]  i_disp_len;
    logic [31:0] i_disp;
    logic [2:0]  i_imm_len;
    logic [31:0] i_imm;
    logic        i_flush;
    logic        o_valid;
    logic [31:0] o_data;
    logic        i_out_ready;
    logic        o_error;
    logic        o_done;
    logic [31:0] o_byte_count;

    modport master (
        output i_start, i_start_addr, i_instr_valid, i_lock, i_opsize16, i_opcode,
               i_modrm, i_has_sib, i_sib, i_disp_len, i_disp, i_imm_len, i_imm,
               i_flush, i_out_ready,
        input  o_instr_ready, o_valid, o_data, o_error, o_done, o_byte_count
    );

    modport slave (
        input  i_start, i_start_addr, i_instr_valid, i_lock, i_opsize16, i_opcode,
               i_modrm, i_has_sib, i_sib, i_disp_len, i_disp, i_imm_len, i_imm,
               i_flush, i_out_ready,
        output o_instr_ready, o_valid, o_data, o_error, o_done, o_byte_count
    );
endinterface

// File: rtl/x86_add_encoder.sv
// Encodes x86 ADD descriptors into a little-endian 32-bit word stream: the start
// address first, then the instruction bytes packed contiguously, padded on flush.
module x86_add_encoder #(
    parameter logic [7:0] PAD_BYTE        = 8'h90,
    parameter int         MAX_INSTR_BYTES = 15
) (
    input logic          i_clk,
    input logic          i_reset,
    x86_add_encoder_if.slave bus
);

    localparam logic [4:0] MAX_LEN = 5'(MAX_INSTR_BYTES);

    typedef enum logic [2:0] {
        IDLE, ADDR, READY, SERIAL, FLUSH, DRAIN, DONE
    } state_t;

    state_t      state_q;
    logic [7:0]  instrBuf_q [15];
    logic [3:0]  len_q;
    logic [3:0]  idx_q;
    logic [1:0]  packCnt_q;
    logic [31:0] wordAcc_q;
    logic [31:0] outData_q;
    logic        outValid_q;
    logic        instrReady_q;
    logic        error_q;
    logic        done_q;
    logic [31:0] byteCount_q;

    logic [7:0]  newBuf_d [15];
    logic [4:0]  instrLen_d;
    logic [3:0]  pos;
    logic        accept;
    logic        outFree;
    logic        lastByte;
    logic [7:0]  curByte;
    logic [31:0] serialWord;
    logic [31:0] padWord;

    assign bus.o_valid       = outValid_q;
    assign bus.o_data        = outData_q;
    assign bus.o_instr_ready = instrReady_q;
    assign bus.o_error       = error_q;
    assign bus.o_done        = done_q;
    assign bus.o_byte_count  = byteCount_q;

    assign outFree  = !outValid_q || bus.i_out_ready;
    assign lastByte = (idx_q == len_q - 4'd1);
    assign curByte  = instrBuf_q[idx_q];

    // Descriptor legality and its byte image in wire order
    always_comb begin
        instrLen_d = 5'(bus.i_lock) + 5'(bus.i_opsize16) + 5'd2 + 5'(bus.i_has_sib)
                   + 5'(bus.i_disp_len) + 5'(bus.i_imm_len);
        accept = (bus.i_disp_len == 3'd0 || bus.i_disp_len == 3'd1 || bus.i_disp_len == 3'd4)
              && (bus.i_imm_len == 3'd0 || bus.i_imm_len == 3'd1 || bus.i_imm_len == 3'd2
                  || bus.i_imm_len == 3'd4)
              && (instrLen_d <= MAX_LEN);
        for (int i = 0; i < 15; i++) newBuf_d[i] = 8'h00;
        pos = 4'd0;
        if (bus.i_lock) begin
            newBuf_d[pos] = 8'hF0;
            pos = pos + 4'd1;
        end
        if (bus.i_opsize16) begin
            newBuf_d[pos] = 8'h66;
            pos = pos + 4'd1;
        end
        newBuf_d[pos] = bus.i_opcode;
        pos = pos + 4'd1;
        newBuf_d[pos] = bus.i_modrm;
        pos = pos + 4'd1;
        if (bus.i_has_sib) begin
            newBuf_d[pos] = bus.i_sib;
            pos = pos + 4'd1;
        end
        for (int k = 0; k < 4; k++) begin
            if (k < int'(bus.i_disp_len)) begin
                newBuf_d[pos] = bus.i_disp[k*8 +: 8];
                pos = pos + 4'd1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (k < int'(bus.i_imm_len)) begin
                newBuf_d[pos] = bus.i_imm[k*8 +: 8];
                pos = pos + 4'd1;
            end
        end
    end

    // Accumulator with the current byte merged in, and the pad-filled final word
    always_comb begin
        serialWord = wordAcc_q;
        case (packCnt_q)
            2'd0:    serialWord[7:0]   = curByte;
            2'd1:    serialWord[15:8]  = curByte;
            2'd2:    serialWord[23:16] = curByte;
            default: serialWord[31:24] = curByte;
        endcase
        padWord = wordAcc_q;
        for (int l = 0; l < 4; l++) begin
            if (2'(l) >= packCnt_q) padWord[l*8 +: 8] = PAD_BYTE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            len_q        <= 4'd0;
            idx_q        <= 4'd0;
            packCnt_q    <= 2'd0;
            wordAcc_q    <= 32'd0;
            outData_q    <= 32'd0;
            outValid_q   <= 1'b0;
            instrReady_q <= 1'b0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            byteCount_q  <= 32'd0;
            for (int i = 0; i < 15; i++) instrBuf_q[i] <= 8'h00;
        end else begin
            error_q <= 1'b0;
            done_q  <= 1'b0;
            if (outValid_q && bus.i_out_ready) outValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_start && outFree) begin
                        outData_q   <= bus.i_start_addr;
                        outValid_q  <= 1'b1;
                        byteCount_q <= 32'd0;
                        packCnt_q   <= 2'd0;
                        wordAcc_q   <= 32'd0;
                        state_q     <= ADDR;
                    end
                end
                ADDR: begin
                    if (outValid_q && bus.i_out_ready) begin
                        state_q      <= READY;
                        instrReady_q <= 1'b1;
                    end
                end
                READY: begin
                    // A descriptor wins over a simultaneous flush
                    if (bus.i_instr_valid) begin
                        if (accept) begin
                            instrBuf_q   <= newBuf_d;
                            len_q        <= instrLen_d[3:0];
                            idx_q        <= 4'd0;
                            state_q      <= SERIAL;
                            instrReady_q <= 1'b0;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end else if (bus.i_flush) begin
                        state_q      <= FLUSH;
                        instrReady_q <= 1'b0;
                    end
                end
                SERIAL: begin
                    if (packCnt_q != 2'd3 || outFree) begin
                        if (packCnt_q == 2'd3) begin
                            outData_q  <= serialWord;
                            outValid_q <= 1'b1;
                            wordAcc_q  <= 32'd0;
                        end else begin
                            wordAcc_q <= serialWord;
                        end
                        packCnt_q   <= packCnt_q + 2'd1;
                        byteCount_q <= byteCount_q + 32'd1;
                        idx_q       <= idx_q + 4'd1;
                        if (lastByte) begin
                            state_q      <= READY;
                            instrReady_q <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (packCnt_q == 2'd0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (outFree) begin
                        outData_q  <= padWord;
                        outValid_q <= 1'b1;
                        packCnt_q  <= 2'd0;
                        wordAcc_q  <= 32'd0;
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outValid_q && bus.i_out_ready) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
